// File: rtl/vram_slot_arbiter_if.sv
// Bus bundle between the VRAM slot arbiter and its neighbours:
// timing generator, tile/attribute fetcher, CPU bus glue and the VRAM.
interface vram_slot_arbiter_if #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 8
);
    // Video timing and fetcher
    logic          PCLK_EN;
    logic [8:0]    HPOS;
    logic          VBLK;
    logic [AW-1:0] VID_ADDR;
    logic [DW-1:0] VID_DATA;
    logic          VID_TSTB;
    logic          VID_ASTB;
    // CPU handshake
    logic          CPU_REQ;
    logic          CPU_WE;
    logic [AW-1:0] CPU_ADDR;
    logic [DW-1:0] CPU_DIN;
    logic [DW-1:0] CPU_DOUT;
    logic          CPU_ACK;
    logic          CPU_WAIT;
    // VRAM port
    logic [AW-1:0] RAM_ADDR;
    logic          RAM_WE;
    logic [DW-1:0] RAM_DIN;
    logic [DW-1:0] RAM_DOUT;

    // Arbiter side
    modport slave (
        input  PCLK_EN, HPOS, VBLK, VID_ADDR,
        input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_DIN,
        input  RAM_DOUT,
        output VID_DATA, VID_TSTB, VID_ASTB,
        output CPU_DOUT, CPU_ACK, CPU_WAIT,
        output RAM_ADDR, RAM_WE, RAM_DIN
    );

    // Environment side
    modport master (
        output PCLK_EN, HPOS, VBLK, VID_ADDR,
        output CPU_REQ, CPU_WE, CPU_ADDR, CPU_DIN,
        output RAM_DOUT,
        input  VID_DATA, VID_TSTB, VID_ASTB,
        input  CPU_DOUT, CPU_ACK, CPU_WAIT,
        input  RAM_ADDR, RAM_WE, RAM_DIN
    );
endinterface

// File: rtl/vram_slot_arbiter.sv
// Shares one single-port synchronous VRAM between pixel-timed tile/attribute
// fetches and a REQ/ACK CPU port. Video owns its slots; the CPU takes any
// other cycle. Every access completes 3 MCLK after issue.
module vram_slot_arbiter #(
    parameter int unsigned AW          = 11,
    parameter int unsigned DW          = 8,
    parameter logic [8:0]  FETCH_START = 9'd504,
    parameter logic [8:0]  FETCH_END   = 9'd336,
    parameter logic [2:0]  TILE_PH     = 3'd0,
    parameter logic [2:0]  ATTR_PH     = 3'd4
) (
    input  logic                MCLK,
    input  logic                RESET,
    vram_slot_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {C_IDLE, C_PEND, C_BUSY} cpu_state_e;
    typedef enum logic [1:0] {SRC_NONE, SRC_TILE, SRC_ATTR, SRC_CPU} src_e;

    typedef struct packed {
        src_e src;
        logic wr;
    } tag_t;

    cpu_state_e    state_q, state_d;
    logic          armed_q, armed_d;
    logic          wait_q;
    logic          lat_load_c, issue_cpu_c;
    logic          fw_c, slot_c, tile_c;
    tag_t          issue_tag_c, tag1_q, tag2_q;

    logic          lat_we_q;
    logic [AW-1:0] lat_addr_q;
    logic [DW-1:0] lat_din_q;

    logic [AW-1:0] ram_addr_q;
    logic          ram_we_q;
    logic [DW-1:0] ram_din_q;
    logic [DW-1:0] vid_data_q, cpu_dout_q;
    logic          vid_tstb_q, vid_astb_q, cpu_ack_q;

    // Video slot decode: the window wraps through HPOS 511 -> 0
    always_comb begin
        fw_c   = !bus.VBLK && ((bus.HPOS >= FETCH_START) || (bus.HPOS < FETCH_END));
        tile_c = (bus.HPOS[2:0] == TILE_PH);
        slot_c = bus.PCLK_EN && fw_c && (tile_c || (bus.HPOS[2:0] == ATTR_PH));
    end

    // CPU FSM next state, request latch/issue decisions and issue tag
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        lat_load_c  = 1'b0;
        issue_cpu_c = 1'b0;
        issue_tag_c = '{src: SRC_NONE, wr: 1'b0};

        if (!bus.CPU_REQ) begin
            armed_d = 1'b1;
        end

        case (state_q)
            C_IDLE: begin
                if (bus.CPU_REQ && armed_q) begin
                    lat_load_c = 1'b1;
                    armed_d    = 1'b0;
                    state_d    = C_PEND;
                end
            end
            C_PEND: begin
                if (!slot_c) begin
                    issue_cpu_c = 1'b1;
                    state_d     = C_BUSY;
                end
            end
            C_BUSY: begin
                if (tag2_q.src == SRC_CPU) begin
                    state_d = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase

        if (slot_c) begin
            issue_tag_c.src = tile_c ? SRC_TILE : SRC_ATTR;
        end else if (issue_cpu_c) begin
            issue_tag_c.src = SRC_CPU;
            issue_tag_c.wr  = lat_we_q;
        end
    end

    // CPU FSM state register
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_q <= C_IDLE;
            armed_q <= 1'b1;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            wait_q  <= (state_d != C_IDLE);
        end
    end

    // Request latch, RAM port, tag pipeline (T+1, T+2) and result stage (T+3)
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            lat_we_q   <= 1'b0;
            lat_addr_q <= '0;
            lat_din_q  <= '0;
            ram_addr_q <= '0;
            ram_we_q   <= 1'b0;
            ram_din_q  <= '0;
            tag1_q     <= '{src: SRC_NONE, wr: 1'b0};
            tag2_q     <= '{src: SRC_NONE, wr: 1'b0};
            vid_data_q <= '0;
            cpu_dout_q <= '0;
            vid_tstb_q <= 1'b0;
            vid_astb_q <= 1'b0;
            cpu_ack_q  <= 1'b0;
        end else begin
            if (lat_load_c) begin
                lat_we_q   <= bus.CPU_WE;
                lat_addr_q <= bus.CPU_ADDR;
                lat_din_q  <= bus.CPU_DIN;
            end

            ram_we_q <= 1'b0;
            if (slot_c) begin
                ram_addr_q <= bus.VID_ADDR;
            end else if (issue_cpu_c) begin
                ram_addr_q <= lat_addr_q;
                ram_we_q   <= lat_we_q;
                ram_din_q  <= lat_din_q;
            end

            tag1_q <= issue_tag_c;
            tag2_q <= tag1_q;

            vid_tstb_q <= (tag2_q.src == SRC_TILE);
            vid_astb_q <= (tag2_q.src == SRC_ATTR);
            cpu_ack_q  <= (tag2_q.src == SRC_CPU);

            if ((tag2_q.src == SRC_TILE) || (tag2_q.src == SRC_ATTR)) begin
                vid_data_q <= bus.RAM_DOUT;
            end
            if ((tag2_q.src == SRC_CPU) && !tag2_q.wr) begin
                cpu_dout_q <= bus.RAM_DOUT;
            end
        end
    end

    assign bus.RAM_ADDR = ram_addr_q;
    assign bus.RAM_WE   = ram_we_q;
    assign bus.RAM_DIN  = ram_din_q;
    assign bus.VID_DATA = vid_data_q;
    assign bus.VID_TSTB = vid_tstb_q;
    assign bus.VID_ASTB = vid_astb_q;
    assign bus.CPU_DOUT = cpu_dout_q;
    assign bus.CPU_ACK  = cpu_ack_q;
    assign bus.CPU_WAIT = wait_q;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Self-checking bench for vram_slot_arbiter: directed vector table plus
// hand-written sequences for slot collision, reset in flight and a full line.
module tb_vram_slot_arbiter;

    logic MCLK;
    logic RESET;

    vram_slot_arbiter_if #(.AW(11), .DW(8)) bus ();

    vram_slot_arbiter dut (
        .MCLK  (MCLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    int checks   = 0;
    int failures = 0;

    // Synchronous VRAM model, read data one MCLK after the address
    logic [7:0] mem [0:2047];
    bit         filled = 1'b0;
    logic [7:0] rd_tmp;

    function automatic logic [7:0] init_val(input logic [10:0] a);
        case (a)
            11'h123: return 8'h5A;
            11'h040: return 8'h11;
            11'h048: return 8'h22;
            11'h44C: return 8'h33;
            11'h050: return 8'h77;
            default: return 8'(a ^ (a >> 3));
        endcase
    endfunction

    always @(posedge MCLK) begin
        if (!filled) begin
            for (int i = 0; i < 2048; i++) mem[i] = init_val(11'(i));
            filled = 1'b1;
        end
        rd_tmp = mem[bus.RAM_ADDR];
        if (bus.RAM_WE) mem[bus.RAM_ADDR] = bus.RAM_DIN;
        bus.RAM_DOUT <= rd_tmp;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge MCLK);
        #1;
    endtask

    typedef struct {
        logic        rst, req, we;
        logic [10:0] addr;
        logic [7:0]  din;
        logic        pen;
        logic [8:0]  hpos;
        logic        vblk;
        logic [10:0] vaddr;
        logic        ack, wt, tstb, astb, rwe;
        logic [10:0] raddr;
        logic [7:0]  dout, vdata;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic req, input logic we, input logic [10:0] addr,
        input logic [7:0] din, input logic pen, input logic [8:0] hpos, input logic vblk,
        input logic [10:0] vaddr, input logic ack, input logic wt, input logic tstb,
        input logic astb, input logic rwe, input logic [10:0] raddr,
        input logic [7:0] dout, input logic [7:0] vdata);
        vec_t v;
        v.rst = rst; v.req = req; v.we = we; v.addr = addr; v.din = din;
        v.pen = pen; v.hpos = hpos; v.vblk = vblk; v.vaddr = vaddr;
        v.ack = ack; v.wt = wt; v.tstb = tstb; v.astb = astb; v.rwe = rwe;
        v.raddr = raddr; v.dout = dout; v.vdata = vdata;
        return v;
    endfunction

    task automatic cpu_read(input string nm, input logic [10:0] a, input logic [7:0] e);
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b0; bus.CPU_ADDR = a;
        tick;
        chk({nm, "_wait"}, 32'(bus.CPU_WAIT), 32'd1);
        tick;
        chk({nm, "_addr"}, 32'(bus.RAM_ADDR), 32'(a));
        tick;
        chk({nm, "_early_ack"}, 32'(bus.CPU_ACK), 32'd0);
        tick;
        chk({nm, "_ack"}, 32'(bus.CPU_ACK), 32'd1);
        chk({nm, "_dout"}, 32'(bus.CPU_DOUT), 32'(e));
        bus.CPU_REQ = 1'b0;
        tick;
        chk({nm, "_ack_drop"}, 32'(bus.CPU_ACK), 32'd0);
    endtask

    vec_t        vecs [23];
    logic [10:0] exp_addr_q [$];
    logic        exp_attr_q [$];
    logic [10:0] qa;
    logic        qattr;
    logic [8:0]  hp;
    logic        slot;
    int          mode, rises, acks, strobes;

    initial begin
        RESET = 1'b1;
        bus.CPU_REQ = 1'b0; bus.CPU_WE = 1'b0; bus.CPU_ADDR = '0; bus.CPU_DIN = '0;
        bus.PCLK_EN = 1'b0; bus.HPOS = '0; bus.VBLK = 1'b1; bus.VID_ADDR = '0;

        //             rst req we addr     din    pen hpos    vb vaddr    | ack wt ts as we raddr    dout   vdata
        vecs[0]  = mk(1, 1, 0, 11'h123, 8'h00, 0, 9'd0,   1, 11'h000,   0, 0, 0, 0, 0, 11'h000, 8'h00, 8'h00);
        vecs[1]  = mk(1, 1, 0, 11'h123, 8'h00, 0, 9'd0,   1, 11'h000,   0, 0, 0, 0, 0, 11'h000, 8'h00, 8'h00);
        vecs[2]  = mk(1, 1, 0, 11'h123, 8'h00, 0, 9'd0,   1, 11'h000,   0, 0, 0, 0, 0, 11'h000, 8'h00, 8'h00);
        vecs[3]  = mk(0, 1, 0, 11'h123, 8'h00, 0, 9'd0,   1, 11'h000,   0, 1, 0, 0, 0, 11'h000, 8'h00, 8'h00);
        vecs[4]  = mk(0, 1, 0, 11'h123, 8'h00, 0, 9'd0,   1, 11'h000,   0, 1, 0, 0, 0, 11'h123, 8'h00, 8'h00);
        vecs[5]  = mk(0, 1, 0, 11'h123, 8'h00, 0, 9'd0,   1, 11'h000,   0, 1, 0, 0, 0, 11'h123, 8'h00, 8'h00);
        vecs[6]  = mk(0, 1, 0, 11'h123, 8'h00, 0, 9'd0,   1, 11'h000,   1, 0, 0, 0, 0, 11'h123, 8'h5A, 8'h00);
        vecs[7]  = mk(0, 1, 0, 11'h123, 8'h00, 0, 9'd0,   1, 11'h000,   0, 0, 0, 0, 0, 11'h123, 8'h5A, 8'h00);
        vecs[8]  = mk(0, 0, 0, 11'h123, 8'h00, 0, 9'd0,   1, 11'h000,   0, 0, 0, 0, 0, 11'h123, 8'h5A, 8'h00);
        vecs[9]  = mk(0, 0, 0, 11'h000, 8'h00, 1, 9'd8,   0, 11'h040,   0, 0, 0, 0, 0, 11'h040, 8'h5A, 8'h00);
        vecs[10] = mk(0, 0, 0, 11'h000, 8'h00, 0, 9'd8,   0, 11'h040,   0, 0, 0, 0, 0, 11'h040, 8'h5A, 8'h00);
        vecs[11] = mk(0, 0, 0, 11'h000, 8'h00, 0, 9'd8,   0, 11'h040,   0, 0, 1, 0, 0, 11'h040, 8'h5A, 8'h11);
        vecs[12] = mk(0, 0, 0, 11'h000, 8'h00, 0, 9'd8,   0, 11'h040,   0, 0, 0, 0, 0, 11'h040, 8'h5A, 8'h11);
        vecs[13] = mk(0, 0, 0, 11'h000, 8'h00, 1, 9'd336, 0, 11'h048,   0, 0, 0, 0, 0, 11'h040, 8'h5A, 8'h11);
        vecs[14] = mk(0, 0, 0, 11'h000, 8'h00, 1, 9'd504, 0, 11'h048,   0, 0, 0, 0, 0, 11'h048, 8'h5A, 8'h11);
        vecs[15] = mk(0, 0, 0, 11'h000, 8'h00, 1, 9'd505, 0, 11'h048,   0, 0, 0, 0, 0, 11'h048, 8'h5A, 8'h11);
        vecs[16] = mk(0, 0, 0, 11'h000, 8'h00, 1, 9'd506, 0, 11'h048,   0, 0, 1, 0, 0, 11'h048, 8'h5A, 8'h22);
        vecs[17] = mk(0, 0, 0, 11'h000, 8'h00, 1, 9'd508, 0, 11'h44C,   0, 0, 0, 0, 0, 11'h44C, 8'h5A, 8'h22);
        vecs[18] = mk(0, 0, 0, 11'h000, 8'h00, 1, 9'd509, 0, 11'h44C,   0, 0, 0, 0, 0, 11'h44C, 8'h5A, 8'h22);
        vecs[19] = mk(0, 0, 0, 11'h000, 8'h00, 1, 9'd510, 0, 11'h44C,   0, 0, 0, 1, 0, 11'h44C, 8'h5A, 8'h33);
        vecs[20] = mk(0, 0, 0, 11'h000, 8'h00, 1, 9'd0,   1, 11'h055,   0, 0, 0, 0, 0, 11'h44C, 8'h5A, 8'h33);
        vecs[21] = mk(0, 0, 0, 11'h000, 8'h00, 1, 9'd4,   1, 11'h055,   0, 0, 0, 0, 0, 11'h44C, 8'h5A, 8'h33);
        vecs[22] = mk(0, 0, 0, 11'h000, 8'h00, 1, 9'd8,   1, 11'h055,   0, 0, 0, 0, 0, 11'h44C, 8'h5A, 8'h33);

        // Table: each row drives one cycle, expectations are the registered outputs after that edge
        for (int i = 0; i < 23; i++) begin
            RESET        = vecs[i].rst;
            bus.CPU_REQ  = vecs[i].req;
            bus.CPU_WE   = vecs[i].we;
            bus.CPU_ADDR = vecs[i].addr;
            bus.CPU_DIN  = vecs[i].din;
            bus.PCLK_EN  = vecs[i].pen;
            bus.HPOS     = vecs[i].hpos;
            bus.VBLK     = vecs[i].vblk;
            bus.VID_ADDR = vecs[i].vaddr;
            tick;
            chk($sformatf("v%0d_ack", i),   32'(bus.CPU_ACK),  32'(vecs[i].ack));
            chk($sformatf("v%0d_wait", i),  32'(bus.CPU_WAIT), 32'(vecs[i].wt));
            chk($sformatf("v%0d_tstb", i),  32'(bus.VID_TSTB), 32'(vecs[i].tstb));
            chk($sformatf("v%0d_astb", i),  32'(bus.VID_ASTB), 32'(vecs[i].astb));
            chk($sformatf("v%0d_we", i),    32'(bus.RAM_WE),   32'(vecs[i].rwe));
            chk($sformatf("v%0d_raddr", i), 32'(bus.RAM_ADDR), 32'(vecs[i].raddr));
            chk($sformatf("v%0d_dout", i),  32'(bus.CPU_DOUT), 32'(vecs[i].dout));
            chk($sformatf("v%0d_vdata", i), 32'(bus.VID_DATA), 32'(vecs[i].vdata));
        end

        // CPU write arriving in the same cycle as an attribute slot
        bus.VBLK = 1'b0; bus.PCLK_EN = 1'b1; bus.HPOS = 9'd12; bus.VID_ADDR = 11'h050;
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_ADDR = 11'h7F7; bus.CPU_DIN = 8'hC3;
        tick;
        chk("coll_video_first", 32'(bus.RAM_ADDR), 32'h050);
        chk("coll_no_we_in_slot", 32'(bus.RAM_WE), 32'd0);
        chk("coll_wait", 32'(bus.CPU_WAIT), 32'd1);
        bus.PCLK_EN = 1'b0;
        tick;
        chk("coll_cpu_addr", 32'(bus.RAM_ADDR), 32'h7F7);
        chk("coll_we", 32'(bus.RAM_WE), 32'd1);
        chk("coll_din", 32'(bus.RAM_DIN), 32'hC3);
        tick;
        chk("coll_we_once", 32'(bus.RAM_WE), 32'd0);
        chk("coll_astb", 32'(bus.VID_ASTB), 32'd1);
        chk("coll_vdata", 32'(bus.VID_DATA), 32'h77);
        tick;
        chk("coll_ack", 32'(bus.CPU_ACK), 32'd1);
        chk("coll_wait_clr", 32'(bus.CPU_WAIT), 32'd0);
        chk("coll_dout_hold", 32'(bus.CPU_DOUT), 32'h5A);
        bus.CPU_REQ = 1'b0;
        tick;
        chk("coll_no_second_we", 32'(bus.RAM_WE), 32'd0);

        // Reset while the CPU access is in flight
        bus.VBLK = 1'b1;
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_ADDR = 11'h3A5; bus.CPU_DIN = 8'h96;
        tick;
        chk("rb_wait", 32'(bus.CPU_WAIT), 32'd1);
        tick;
        chk("rb_we", 32'(bus.RAM_WE), 32'd1);
        chk("rb_addr", 32'(bus.RAM_ADDR), 32'h3A5);
        RESET = 1'b1;
        tick;
        chk("rb_rst_ack", 32'(bus.CPU_ACK), 32'd0);
        chk("rb_rst_wait", 32'(bus.CPU_WAIT), 32'd0);
        chk("rb_rst_we", 32'(bus.RAM_WE), 32'd0);
        chk("rb_rst_addr", 32'(bus.RAM_ADDR), 32'd0);
        chk("rb_rst_dout", 32'(bus.CPU_DOUT), 32'd0);
        chk("rb_rst_vdata", 32'(bus.VID_DATA), 32'd0);
        tick;
        RESET = 1'b0; bus.CPU_REQ = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk($sformatf("rb_post_ack%0d", i), 32'(bus.CPU_ACK), 32'd0);
            chk($sformatf("rb_post_wait%0d", i), 32'(bus.CPU_WAIT), 32'd0);
        end
        cpu_read("rd_3a5", 11'h3A5, 8'h96);
        cpu_read("rd_7f7", 11'h7F7, 8'hC3);

        // Whole active line with CPU_REQ mostly held high
        bus.VBLK = 1'b0; bus.CPU_WE = 1'b0; bus.CPU_ADDR = 11'h7F0; bus.CPU_DIN = 8'h00;
        mode = -1; rises = 1; acks = 0; strobes = 0;
        for (int n = 0; n < 375; n++) begin
            hp = 9'(496 + n);
            bus.HPOS     = hp;
            bus.VID_ADDR = {2'b00, hp};
            bus.PCLK_EN  = (n < 361);
            if (n >= 362) begin
                bus.CPU_REQ = 1'b0;
            end else if (mode > 0) begin
                bus.CPU_REQ = 1'b1; mode--;
            end else if (mode == 0) begin
                bus.CPU_REQ = 1'b0; mode = -2;
            end else if (mode == -2) begin
                bus.CPU_REQ = 1'b1; rises++; mode = -1;
            end else begin
                bus.CPU_REQ = 1'b1;
            end
            slot = bus.PCLK_EN && ((hp >= 9'd504) || (hp < 9'd336)) &&
                   ((hp[2:0] == 3'd0) || (hp[2:0] == 3'd4));
            if (slot) begin
                exp_addr_q.push_back({2'b00, hp});
                exp_attr_q.push_back(hp[2:0] == 3'd4);
            end
            tick;
            if (slot) chk($sformatf("line_slot_addr_h%0d", hp), 32'(bus.RAM_ADDR), 32'({2'b00, hp}));
            if (bus.VID_TSTB || bus.VID_ASTB) begin
                strobes++;
                if (exp_addr_q.size() == 0) begin
                    chk("line_stray_strobe", 32'd1, 32'd0);
                end else begin
                    qa    = exp_addr_q.pop_front();
                    qattr = exp_attr_q.pop_front();
                    chk($sformatf("line_kind_a%0h", qa), 32'({bus.VID_TSTB, bus.VID_ASTB}),
                        qattr ? 32'd1 : 32'd2);
                    chk($sformatf("line_vdata_a%0h", qa), 32'(bus.VID_DATA), 32'(mem[qa]));
                end
            end
            if (bus.CPU_ACK) begin
                acks++;
                mode = 3;
            end
        end
        chk("line_ack_per_req", 32'(acks), 32'(rises));
        chk("line_strobe_count", 32'(strobes), 32'd86);
        chk("line_queue_empty", 32'(exp_addr_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
